systolic_scheduler: RTL and testbench
=====================================

SYSTOLIC_SCHEDULER -- requirements
Module: systolic_scheduler

Interface
REQ-001 SHALL have parameter ROWS, default 4, PE array rows.
REQ-002 SHALL have parameter COLS, default 4, PE array columns.
REQ-003 SHALL have parameter VECTOR_LENGTH, default 4, dot-product length K per PE.
REQ-004 SHALL have parameter INPUT_WIDTH, default `SYSTOLIC_INPUT_WIDTH, operand width.
REQ-005 SHALL have parameter ACC_WIDTH, default `SYSTOLIC_RESULT_WIDTH, accumulator width.
REQ-006 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin one tile.
- busy  out  1  tile in progress.
- done  out  1  one-cycle pulse at tile end.
- fetch_en  out  1  operand buffer read strobe.
- fetch_k  out  clog2(VECTOR_LENGTH)  K index read.
- a_slice  in  ROWS*INPUT_WIDTH  A column k; valid 1 cycle after fetch_en.
- b_slice  in  COLS*INPUT_WIDTH  B row k; valid 1 cycle after fetch_en.
- pe_clear  out  1  PE clear.
- a_feed  out  ROWS*INPUT_WIDTH  skewed west-edge operands.
- a_feed_valid  out  ROWS  per-row valid.
- b_feed  out  COLS*INPUT_WIDTH  skewed north-edge operands.
- b_feed_valid  out  COLS  per-column valid.
- acc_valid_vec  in  ROWS*COLS  PE acc_valid, index r*COLS+c.
- acc_flat  in  ROWS*COLS*ACC_WIDTH  PE acc_value, same indexing.
- res_data  out  ACC_WIDTH  drained result.
- res_idx  out  clog2(ROWS*COLS)  row-major index of res_data.
- res_valid  out  1  result handshake valid.
- res_ready  in  1  result handshake ready.
- error  out  1  watchdog expiry, sticky until next start.

Function
REQ-007 SHALL implement FSM IDLE, CLEAR, FEED, WAIT, DRAIN, FIN.
REQ-008 IDLE: start=1 -> CLEAR; start SHALL be ignored in all other states.
REQ-009 CLEAR: pe_clear=1 exactly one cycle -> FEED.
REQ-010 FEED: fetch_en=1 for VECTOR_LENGTH consecutive cycles, fetch_k 0..VECTOR_LENGTH-1 ascending, then -> WAIT.
REQ-011 Slice data SHALL be captured the cycle after each fetch_en, with a capture-valid bit.
REQ-012 Row r operand/valid SHALL appear on a_feed/a_feed_valid r+1 cycles after capture (skew r); column c likewise with skew c.
REQ-013 Skew pipeline SHALL run independent of FSM state, so trailing operands drain during WAIT.
REQ-014 Skew stages carrying invalid SHALL present data 0 and valid 0.
REQ-015 WAIT -> DRAIN when all acc_valid_vec bits are 1.
REQ-016 DRAIN: res_idx from 0; res_data = acc_flat slice res_idx; res_valid=1.
REQ-017 res_idx SHALL advance only when res_valid&res_ready; res_data stable while stalled.
REQ-018 Transfer at res_idx=ROWS*COLS-1 -> FIN; no wrap.
REQ-019 FIN: done=1 one cycle -> IDLE.
REQ-020 busy=1 in all states except IDLE.
REQ-021 Multiply-accumulate arithmetic SHALL remain in PEs; block SHALL not alter operand or result values.

Reset
REQ-022 rst=1 SHALL, mid-operation included, force IDLE; busy, done, fetch_en, fetch_k, pe_clear, feeds, valids, res_data, res_idx, res_valid, error SHALL be 0 next cycle.
REQ-023 Skew registers and counters SHALL clear on rst.

Configuration
REQ-024 With SYSTOLIC_SCHED_TIMEOUT_EN defined: WAIT cycle counter, localparam WAIT_LIMIT = 4*(VECTOR_LENGTH+ROWS+COLS); reaching WAIT_LIMIT sets error=1 -> FIN, skipping DRAIN.
REQ-025 Without SYSTOLIC_SCHED_TIMEOUT_EN: no counter; error tied 0; WAIT unbounded.

Structure
REQ-026 FSM state enum and index-width helper constants SHALL live in package systolic_pkg.
REQ-027 Skew SHALL be one parameterised sub-module skew_line (DEPTH, WIDTH, valid bit), instantiated per row and column.

Verification
REQ-028 ROWS=COLS=2, VECTOR_LENGTH=4, start -> pe_clear 1 cycle, 4 fetch_en cycles fetch_k 0,1,2,3, done once.
REQ-029 a_slice row1 k=0 value 7 -> a_feed row0 and row1 one cycle apart, row1 later, b same.
REQ-030 acc_valid_vec=4'b1111, acc_flat {40,30,20,10}, res_ready=1 -> res_data 10,20,30,40 consecutively, res_idx 0..3.
REQ-031 res_ready low 3 cycles at idx 1 -> res_data 20 held, res_valid high, no skip.
REQ-032 rst in FEED -> all outputs 0 next cycle, IDLE; start accepted after.
REQ-033 With SYSTOLIC_SCHED_TIMEOUT_EN, acc_valid_vec stuck 4'b0111 -> error=1 after 32 WAIT cycles, done pulse, no res_valid.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: scheduler state encoding, default widths and index sizing helper.
`ifndef SYSTOLIC_INPUT_WIDTH
`define SYSTOLIC_INPUT_WIDTH 8
`endif
`ifndef SYSTOLIC_RESULT_WIDTH
`define SYSTOLIC_RESULT_WIDTH 32
`endif

package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_FIN   = 3'd5
    } sched_state_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_scheduler_skew_line.sv
// skew_line: DEPTH-stage delay line carrying operand data plus a valid bit.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // Data is zeroed at entry so every bubble stage reads as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= in_valid ? in_data : '0;
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_scheduler.sv
// systolic_scheduler: sequences one tile (clear, feed with skew, wait, drain).
// Optional WAIT watchdog enabled by defining SYSTOLIC_SCHED_TIMEOUT_EN.
`ifndef SYSTOLIC_INPUT_WIDTH
`define SYSTOLIC_INPUT_WIDTH 8
`endif
`ifndef SYSTOLIC_RESULT_WIDTH
`define SYSTOLIC_RESULT_WIDTH 32
`endif

module systolic_scheduler
    import systolic_pkg::*;
#(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int VECTOR_LENGTH = 4,
    parameter int INPUT_WIDTH   = `SYSTOLIC_INPUT_WIDTH,
    parameter int ACC_WIDTH     = `SYSTOLIC_RESULT_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    fetch_en,
    output logic [idx_width(VECTOR_LENGTH)-1:0]     fetch_k,
    input  logic [ROWS*INPUT_WIDTH-1:0]             a_slice,
    input  logic [COLS*INPUT_WIDTH-1:0]             b_slice,
    output logic                                    pe_clear,
    output logic [ROWS*INPUT_WIDTH-1:0]             a_feed,
    output logic [ROWS-1:0]                         a_feed_valid,
    output logic [COLS*INPUT_WIDTH-1:0]             b_feed,
    output logic [COLS-1:0]                         b_feed_valid,
    input  logic [ROWS*COLS-1:0]                    acc_valid_vec,
    input  logic [ROWS*COLS*ACC_WIDTH-1:0]          acc_flat,
    output logic [ACC_WIDTH-1:0]                    res_data,
    output logic [idx_width(ROWS*COLS)-1:0]         res_idx,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic                                    error
);

    localparam int KW  = idx_width(VECTOR_LENGTH);
    localparam int NPE = ROWS * COLS;
    localparam int RW  = idx_width(NPE);
    localparam logic [KW-1:0] K_LAST   = KW'(VECTOR_LENGTH - 1);
    localparam logic [RW-1:0] RES_LAST = RW'(NPE - 1);

    sched_state_t state, next_state;

    logic [KW-1:0] k_cnt;
    logic [RW-1:0] res_cnt;
    logic          wait_expired;
    logic          all_valid;

    logic                        fetch_d;
    logic                        cap_v;
    logic [ROWS*INPUT_WIDTH-1:0] cap_a;
    logic [COLS*INPUT_WIDTH-1:0] cap_b;

    assign all_valid = &acc_valid_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        fetch_en   = 1'b0;
        pe_clear   = 1'b0;
        res_valid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                pe_clear   = 1'b1;
                next_state = ST_FEED;
            end
            ST_FEED: begin
                fetch_en = 1'b1;
                if (k_cnt == K_LAST) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (all_valid) begin
                    next_state = ST_DRAIN;
                end else if (wait_expired) begin
                    next_state = ST_FIN;
                end
            end
            ST_DRAIN: begin
                res_valid = 1'b1;
                if (res_ready && (res_cnt == RES_LAST)) begin
                    next_state = ST_FIN;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_cnt <= '0;
        end else if (state == ST_FEED) begin
            k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
        end else begin
            k_cnt <= '0;
        end
    end

    // Index holds at the last entry once drained; it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt <= '0;
        end else if (state != ST_DRAIN) begin
            res_cnt <= '0;
        end else if (res_ready && (res_cnt != RES_LAST)) begin
            res_cnt <= res_cnt + 1'b1;
        end
    end

    assign fetch_k  = fetch_en ? k_cnt : '0;
    assign res_idx  = res_valid ? res_cnt : '0;
    assign res_data = res_valid ?
        acc_flat[int'(res_cnt)*ACC_WIDTH +: ACC_WIDTH] : '0;

    // Buffer returns data one cycle after the strobe; capture it then.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_d <= 1'b0;
            cap_v   <= 1'b0;
            cap_a   <= '0;
            cap_b   <= '0;
        end else begin
            fetch_d <= fetch_en;
            cap_v   <= fetch_d;
            cap_a   <= fetch_d ? a_slice : '0;
            cap_b   <= fetch_d ? b_slice : '0;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_line #(
            .DEPTH (r + 1),
            .WIDTH (INPUT_WIDTH)
        ) u_skew_a (
            .clk       (clk),
            .rst       (rst),
            .in_data   (cap_a[r*INPUT_WIDTH +: INPUT_WIDTH]),
            .in_valid  (cap_v),
            .out_data  (a_feed[r*INPUT_WIDTH +: INPUT_WIDTH]),
            .out_valid (a_feed_valid[r])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        skew_line #(
            .DEPTH (c + 1),
            .WIDTH (INPUT_WIDTH)
        ) u_skew_b (
            .clk       (clk),
            .rst       (rst),
            .in_data   (cap_b[c*INPUT_WIDTH +: INPUT_WIDTH]),
            .in_valid  (cap_v),
            .out_data  (b_feed[c*INPUT_WIDTH +: INPUT_WIDTH]),
            .out_valid (b_feed_valid[c])
        );
    end

`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
    localparam int WAIT_LIMIT = 4 * (VECTOR_LENGTH + ROWS + COLS);
    localparam int WCW        = idx_width(WAIT_LIMIT);

    logic [WCW-1:0] wait_cnt;
    logic           err_q;

    assign wait_expired = (wait_cnt == WCW'(WAIT_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Sticky until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            err_q <= 1'b0;
        end else if ((state == ST_WAIT) && (next_state == ST_FIN)) begin
            err_q <= 1'b1;
        end
    end

    assign error = err_q;
`else
    assign wait_expired = 1'b0;
    assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_scheduler.sv
// tb_systolic_scheduler: directed checks of tile sequencing, skew, drain and reset.
module tb_systolic_scheduler;

    localparam int IW = 8;
    localparam int AW = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        fetch_en;
    logic [1:0]  fetch_k;
    logic [15:0] a_slice;
    logic [15:0] b_slice;
    logic        pe_clear;
    logic [15:0] a_feed;
    logic [1:0]  a_feed_valid;
    logic [15:0] b_feed;
    logic [1:0]  b_feed_valid;
    logic [3:0]  acc_valid_vec;
    logic [63:0] acc_flat;
    logic [15:0] res_data;
    logic [1:0]  res_idx;
    logic        res_valid;
    logic        res_ready;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;
    int saw_done = 0;
    int saw_rv   = 0;

    systolic_scheduler #(
        .ROWS          (2),
        .COLS          (2),
        .VECTOR_LENGTH (4),
        .INPUT_WIDTH   (IW),
        .ACC_WIDTH     (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .fetch_en      (fetch_en),
        .fetch_k       (fetch_k),
        .a_slice       (a_slice),
        .b_slice       (b_slice),
        .pe_clear      (pe_clear),
        .a_feed        (a_feed),
        .a_feed_valid  (a_feed_valid),
        .b_feed        (b_feed),
        .b_feed_valid  (b_feed_valid),
        .acc_valid_vec (acc_valid_vec),
        .acc_flat      (acc_flat),
        .res_data      (res_data),
        .res_idx       (res_idx),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] a_val(input int r, input int k);
        if (r == 1 && k == 0) return 8'd7;
        return 8'(16 * r + k + 1);
    endfunction

    function automatic logic [7:0] b_val(input int c, input int k);
        if (c == 1 && k == 0) return 8'd7;
        return 8'(32 + 16 * c + k);
    endfunction

    function automatic logic [15:0] pack_a(input int k);
        logic [15:0] v;
        v = '0;
        for (int r = 0; r < 2; r++) v[r*IW +: IW] = a_val(r, k);
        return v;
    endfunction

    function automatic logic [15:0] pack_b(input int k);
        logic [15:0] v;
        v = '0;
        for (int c = 0; c < 2; c++) v[c*IW +: IW] = b_val(c, k);
        return v;
    endfunction

    // One clock; acts as the operand buffer with one-cycle read latency.
    task automatic step();
        logic       fe;
        logic [1:0] fk;
        fe = fetch_en;
        fk = fetch_k;
        @(posedge clk);
        #1;
        a_slice = fe ? pack_a(int'(fk)) : '0;
        b_slice = fe ? pack_b(int'(fk)) : '0;
        if (done) saw_done++;
        if (res_valid) saw_rv++;
    endtask

    task automatic start_tile();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " fetch_en"}, 64'(fetch_en), 64'd0);
        check({tag, " fetch_k"}, 64'(fetch_k), 64'd0);
        check({tag, " pe_clear"}, 64'(pe_clear), 64'd0);
        check({tag, " a_feed"}, 64'({a_feed, a_feed_valid}), 64'd0);
        check({tag, " b_feed"}, 64'({b_feed, b_feed_valid}), 64'd0);
        check({tag, " res"}, 64'({res_data, res_idx, res_valid}), 64'd0);
        check({tag, " error"}, 64'(error), 64'd0);
    endtask

    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [1:0]  exp_av;
    logic [1:0]  exp_bv;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a_slice = '0;
        b_slice = '0;
        acc_valid_vec = '0;
        acc_flat = '0;
        res_ready = 1'b0;
        #1;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Tile 1: clear, feed with skew, drain at full rate.
        start_tile();
        for (int t = 0; t < 12; t++) begin
            exp_a = '0; exp_b = '0; exp_av = '0; exp_bv = '0;
            for (int r = 0; r < 2; r++) begin
                int k;
                k = t - 4 - r;
                if (k >= 0 && k < 4) begin
                    exp_av[r] = 1'b1;
                    exp_a[r*IW +: IW] = a_val(r, k);
                    exp_bv[r] = 1'b1;
                    exp_b[r*IW +: IW] = b_val(r, k);
                end
            end
            check($sformatf("pe_clear t%0d", t), 64'(pe_clear), 64'(t == 0));
            check($sformatf("fetch_en t%0d", t), 64'(fetch_en),
                  64'(t >= 1 && t <= 4));
            check($sformatf("fetch_k t%0d", t), 64'(fetch_k),
                  (t >= 1 && t <= 4) ? 64'(t - 1) : 64'd0);
            check($sformatf("a_feed t%0d", t), 64'({a_feed_valid, a_feed}),
                  64'({exp_av, exp_a}));
            check($sformatf("b_feed t%0d", t), 64'({b_feed_valid, b_feed}),
                  64'({exp_bv, exp_b}));
            check($sformatf("busy t%0d", t), 64'({busy, done, res_valid}),
                  64'(3'b100));
            step();
        end
        acc_valid_vec = 4'b1111;
        acc_flat = {16'd40, 16'd30, 16'd20, 16'd10};
        res_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), 64'({res_valid, res_idx, res_data}),
                  64'({1'b1, 2'(i), 16'(10 * (i + 1))}));
            step();
        end
        check("fin done", 64'({done, busy, res_valid}), 64'(3'b110));
        step();
        check("idle after fin", 64'({done, busy}), 64'd0);
        check("done count", 64'(saw_done), 64'd1);

        // Tile 2: start ignored while busy, backpressure at index 1.
        acc_valid_vec = '0;
        start_tile();
        for (int t = 0; t < 5; t++) step();
        start = 1'b1;
        for (int t = 0; t < 3; t++) begin
            check($sformatf("start ignored %0d", t),
                  64'({busy, fetch_en, pe_clear}), 64'(3'b100));
            step();
        end
        start = 1'b0;
        acc_valid_vec = 4'b1111;
        step();
        check("stall idx0", 64'({res_valid, res_idx, res_data}),
              64'({1'b1, 2'd0, 16'd10}));
        step();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall hold%0d", i), 64'({res_valid, res_idx, res_data}),
                  64'({1'b1, 2'd1, 16'd20}));
            step();
        end
        res_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check($sformatf("stall resume%0d", i), 64'({res_valid, res_idx, res_data}),
                  64'({1'b1, 2'(i), 16'(10 * (i + 1))}));
            step();
        end
        check("stall fin", 64'({done, res_valid}), 64'(2'b10));
        step();

        // Reset in the last FEED cycle, with row 0 already feeding.
        acc_valid_vec = '0;
        start_tile();
        for (int t = 0; t < 4; t++) step();
        check("pre-rst feed", 64'({fetch_en, fetch_k, a_feed_valid}),
              64'({1'b1, 2'd3, 2'b01}));
        rst = 1'b1;
        step();
        check_all_zero("mid rst");
        rst = 1'b0;
        step();
        check("idle after rst", 64'(busy), 64'd0);
        start_tile();
        check("restart clear", 64'({pe_clear, busy}), 64'(2'b11));
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Stuck accumulator valids in WAIT.
        acc_valid_vec = 4'b0111;
        saw_done = 0;
        saw_rv = 0;
        start_tile();
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
        for (int t = 0; t < 36; t++) step();
        check("wd last wait", 64'({busy, done, error}), 64'(3'b100));
        check("wd no early done", 64'(saw_done), 64'd0);
        step();
        check("wd fin", 64'({busy, done, error, res_valid}), 64'(4'b1110));
        step();
        check("wd sticky", 64'({busy, done, error}), 64'(3'b001));
        check("wd no res_valid", 64'(saw_rv), 64'd0);
        check("wd done once", 64'(saw_done), 64'd1);
        start_tile();
        check("wd clear on start", 64'({error, pe_clear}), 64'(2'b01));
`else
        for (int t = 0; t < 60; t++) step();
        check("stuck wait busy", 64'({busy, error, res_valid}), 64'(3'b100));
        check("stuck wait no done", 64'(saw_done), 64'd0);
        check("stuck wait no res", 64'(saw_rv), 64'd0);
`endif
        rst = 1'b1;
        step();
        check_all_zero("final rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
